life_engine: RTL and testbench

LIFE_ENGINE -- requirements
Module: life_engine

---
 rtl/lifegame_pkg.sv | 29 ++
 rtl/life_rule.sv | 31 +++
 rtl/life_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_life_engine.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifegame_pkg.sv
// Shared definitions for the Game-of-Life engine.
// Holds the grid geometry, the engine state encoding and a helper that maps
// (x, y) cell coordinates to the linear buffer index y*40 + x.
package lifegame_pkg;

  localparam int unsigned GRID_W = 40;
  localparam int unsigned GRID_H = 30;
  localparam int unsigned GRID_N = 1200;

  // Last valid coordinate/index values, typed to the widths used in the engine
  localparam logic [5:0]  X_MAX   = 6'd39;
  localparam logic [4:0]  Y_MAX   = 5'd29;
  localparam logic [10:0] IDX_MAX = 11'd1199;

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_IDLE = 2'd1,
    ST_CALC = 2'd2,
    ST_SWAP = 2'd3
  } state_e;

  // y*40 + x built from shifts: y*32 + y*8 + x (max 1199, fits 11 bits)
  function automatic logic [10:0] cell_index(input logic [5:0] x, input logic [4:0] y);
    logic [10:0] y_ext;
    y_ext = {6'd0, y};
    return (y_ext << 5) + (y_ext << 3) + {5'd0, x};
  endfunction

endpackage

// File: rtl/life_rule.sv
// Combinational B3/S23 cell update.
// Ports:
//   nbr_i [7:0] : the eight neighbour states of the cell
//   cur_i       : current state of the cell
//   nxt_o       : next-generation state (born on 3, survives on 2 or 3)
module life_rule
  import lifegame_pkg::*;
(
  input  logic [7:0] nbr_i,
  input  logic       cur_i,
  output logic       nxt_o
);

  logic [3:0] cnt_s;

  // Population count of the neighbourhood followed by the B3/S23 decision
  always_comb begin
    cnt_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_s = cnt_s + {3'd0, nbr_i[i]};
    end
    if (cnt_s == 4'd3) begin
      nxt_o = 1'b1;
    end else if (cnt_s == 4'd2) begin
      nxt_o = cur_i;
    end else begin
      nxt_o = 1'b0;
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life engine for a 40x30 toroidal grid, double buffered.
// The front buffer is displayed; each generation is computed one cell per
// clock into the back buffer, then the roles are swapped in a single cycle.
// Ports:
//   clk         : pixel clock, sole clock
//   rst         : synchronous active-high reset
//   seed        : random bit written into the front buffer during SEED
//   reseed      : pulse requesting a new random grid (honoured in IDLE only)
//   frame_start : vertical-blank pulse; GEN_DIV of them trigger a generation
//   rd_x, rd_y  : cell requested by the display stage
//   rd_cell     : registered front-buffer cell state (0 when off-grid)
//   busy        : high in SEED, CALC and SWAP
//   gen_count   : generations completed since the last seed, wrapping
module life_engine
  import lifegame_pkg::*;
#(
  parameter int unsigned GEN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed,
  input  logic        reseed,
  input  logic        frame_start,
  input  logic [5:0]  rd_x,
  input  logic [4:0]  rd_y,
  output logic        rd_cell,
  output logic        busy,
  output logic [15:0] gen_count
);

  localparam logic [7:0] GEN_DIV_C = 8'(GEN_DIV);

  state_e              state_q, state_d;
  logic [10:0]         idx_q, idx_d;
  logic [5:0]          cx_q, cx_d;
  logic [4:0]          cy_q, cy_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic [15:0]         gen_cnt_q, gen_cnt_d;
  logic                front_sel_q, front_sel_d;
  logic                rd_cell_q, busy_q;
  logic [GRID_N-1:0]   buf0_q, buf1_q;
  logic [GRID_N-1:0]   front_s;

  // Scan-position helpers and buffer write controls
  logic [10:0]         idx_inc_s;
  logic [5:0]          cx_inc_s;
  logic [4:0]          cy_inc_s;
  logic                scan_last_s;
  logic                wr_en_s, wr_sel_s, wr_bit_s;

  // Neighbourhood of the cell under calculation
  logic [5:0]          xm_s, xp_s;
  logic [4:0]          ym_s, yp_s;
  logic [7:0]          nbr_s;
  logic                cur_s, nxt_s;
  logic                rd_bit_s;

  assign front_s = front_sel_q ? buf1_q : buf0_q;

  // Raster-order advance of (idx, x, y) shared by SEED and CALC
  always_comb begin
    scan_last_s = (idx_q == IDX_MAX);
    idx_inc_s   = idx_q + 11'd1;
    if (cx_q == X_MAX) begin
      cx_inc_s = 6'd0;
      if (cy_q == Y_MAX) begin
        cy_inc_s = 5'd0;
      end else begin
        cy_inc_s = cy_q + 5'd1;
      end
    end else begin
      cx_inc_s = cx_q + 6'd1;
      cy_inc_s = cy_q;
    end
  end

  // Toroidal neighbour coordinates and the eight neighbour bits
  always_comb begin
    if (cx_q == 6'd0) begin
      xm_s = X_MAX;
    end else begin
      xm_s = cx_q - 6'd1;
    end
    if (cx_q == X_MAX) begin
      xp_s = 6'd0;
    end else begin
      xp_s = cx_q + 6'd1;
    end
    if (cy_q == 5'd0) begin
      ym_s = Y_MAX;
    end else begin
      ym_s = cy_q - 5'd1;
    end
    if (cy_q == Y_MAX) begin
      yp_s = 5'd0;
    end else begin
      yp_s = cy_q + 5'd1;
    end
    nbr_s = {front_s[cell_index(xm_s, ym_s)], front_s[cell_index(cx_q, ym_s)],
             front_s[cell_index(xp_s, ym_s)], front_s[cell_index(xm_s, cy_q)],
             front_s[cell_index(xp_s, cy_q)], front_s[cell_index(xm_s, yp_s)],
             front_s[cell_index(cx_q, yp_s)], front_s[cell_index(xp_s, yp_s)]};
    cur_s = front_s[idx_q];
  end

  life_rule u_rule (
    .nbr_i (nbr_s),
    .cur_i (cur_s),
    .nxt_o (nxt_s)
  );

  // Next-state logic for the engine FSM and its counters
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    frame_cnt_d = frame_cnt_q;
    gen_cnt_d   = gen_cnt_q;
    front_sel_d = front_sel_q;
    wr_en_s     = 1'b0;
    wr_sel_s    = front_sel_q;
    wr_bit_s    = 1'b0;
    case (state_q)
      ST_SEED: begin
        wr_en_s  = 1'b1;
        wr_sel_s = front_sel_q;
        wr_bit_s = seed;
        if (scan_last_s) begin
          state_d = ST_IDLE;
          idx_d   = 11'd0;
          cx_d    = 6'd0;
          cy_d    = 5'd0;
        end else begin
          idx_d = idx_inc_s;
          cx_d  = cx_inc_s;
          cy_d  = cy_inc_s;
        end
      end
      ST_IDLE: begin
        // reseed takes priority over a frame pulse and discards the count
        if (reseed) begin
          state_d     = ST_SEED;
          frame_cnt_d = 8'd0;
          gen_cnt_d   = 16'd0;
          idx_d       = 11'd0;
          cx_d        = 6'd0;
          cy_d        = 5'd0;
        end else if (frame_start) begin
          if ((frame_cnt_q + 8'd1) == GEN_DIV_C) begin
            frame_cnt_d = 8'd0;
            state_d     = ST_CALC;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      ST_CALC: begin
        wr_en_s  = 1'b1;
        wr_sel_s = ~front_sel_q;
        wr_bit_s = nxt_s;
        if (scan_last_s) begin
          state_d = ST_SWAP;
          idx_d   = 11'd0;
          cx_d    = 6'd0;
          cy_d    = 5'd0;
        end else begin
          idx_d = idx_inc_s;
          cx_d  = cx_inc_s;
          cy_d  = cy_inc_s;
        end
      end
      ST_SWAP: begin
        front_sel_d = ~front_sel_q;
        gen_cnt_d   = gen_cnt_q + 16'd1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_SEED;
        idx_d   = 11'd0;
        cx_d    = 6'd0;
        cy_d    = 5'd0;
      end
    endcase
  end

  // Display read: off-grid coordinates return 0 without touching the buffer
  always_comb begin
    if ((rd_x < 6'd40) && (rd_y < 5'd30)) begin
      rd_bit_s = front_s[cell_index(rd_x, rd_y)];
    end else begin
      rd_bit_s = 1'b0;
    end
  end

  // Control state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEED;
      idx_q       <= 11'd0;
      cx_q        <= 6'd0;
      cy_q        <= 5'd0;
      frame_cnt_q <= 8'd0;
      gen_cnt_q   <= 16'd0;
      front_sel_q <= 1'b0;
      rd_cell_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      frame_cnt_q <= frame_cnt_d;
      gen_cnt_q   <= gen_cnt_d;
      front_sel_q <= front_sel_d;
      rd_cell_q   <= rd_bit_s;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Cell buffers: contents need no reset because SEED rewrites the front fully
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      if (wr_sel_s) begin
        buf1_q[idx_q] <= wr_bit_s;
      end else begin
        buf0_q[idx_q] <= wr_bit_s;
      end
    end
  end

  assign rd_cell   = rd_cell_q;
  assign busy      = busy_q;
  assign gen_count = gen_cnt_q;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: a grid-level reference model stepped
// once per clock, a per-cycle compare process, and hand-computed checks on
// known patterns (full grid, blinkers with and without wrap, reset timing).
module tb_life_engine;

  localparam int GDIV = 4;

  logic        clk = 1'b0;
  logic        rst, seed, reseed, frame_start;
  logic [5:0]  rd_x;
  logic [4:0]  rd_y;
  logic        rd_cell, busy;
  logic [15:0] gen_count;

  always #5 clk = ~clk;

  life_engine #(.GEN_DIV(GDIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .seed        (seed),
    .reseed      (reseed),
    .frame_start (frame_start),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_cell     (rd_cell),
    .busy        (busy),
    .gen_count   (gen_count)
  );

  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;
  bit  rd_rand = 1'b1;

  // Reference model: mode 0 = seeding, 1 = idle, 2 = computing a generation
  int          m_mode, m_pos, m_frames, m_left;
  logic [15:0] m_gen;
  bit          m_busy, m_rd, m_rd_valid;
  bit          mf[1200];
  bit          mk[1200];
  bit          pat[1200];

  task automatic next_generation();
    bit nx[1200];
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 40; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx != 0 || dy != 0)
              n += mf[((y + dy + 30) % 30) * 40 + ((x + dx + 40) % 40)];
          end
        end
        nx[y*40+x] = (n == 3) || (n == 2 && mf[y*40+x]);
      end
    end
    mf = nx;
  endtask

  task automatic model_step();
    if (rst) begin
      m_rd = 1'b0; m_rd_valid = 1'b1;
    end else if (rd_x >= 6'd40 || rd_y >= 5'd30) begin
      m_rd = 1'b0; m_rd_valid = 1'b1;
    end else begin
      m_rd       = mf[int'(rd_y) * 40 + int'(rd_x)];
      m_rd_valid = mk[int'(rd_y) * 40 + int'(rd_x)];
    end
    if (rst) begin
      m_mode = 0; m_pos = 0; m_frames = 0; m_gen = 16'd0;
      for (int i = 0; i < 1200; i++) mk[i] = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          mf[m_pos] = seed; mk[m_pos] = 1'b1; m_pos++;
          if (m_pos == 1200) m_mode = 1;
        end
        1: begin
          if (reseed) begin
            m_mode = 0; m_pos = 0; m_frames = 0; m_gen = 16'd0;
          end else if (frame_start) begin
            m_frames++;
            if (m_frames == GDIV) begin
              m_frames = 0; m_mode = 2; m_left = 1201;
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            next_generation();
            m_gen = m_gen + 16'd1;
            m_mode = 1;
          end
        end
      endcase
    end
    m_busy = (m_mode != 1);
  endtask

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (busy !== m_busy) begin
        n_fail++;
        $display("FAIL model_busy: got %b expected %b at %0t", busy, m_busy, $time);
      end
      n_cmp++;
      if (gen_count !== m_gen) begin
        n_fail++;
        $display("FAIL model_gen: got %0d expected %0d at %0t", gen_count, m_gen, $time);
      end
      if (m_rd_valid) begin
        n_cmp++;
        if (rd_cell !== m_rd) begin
          n_fail++;
          $display("FAIL model_rd: got %b expected %b at %0t", rd_cell, m_rd, $time);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    if (rd_rand) begin
      rd_x = 6'($urandom_range(0, 63));
      rd_y = 5'($urandom_range(0, 31));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic read_lit(input string name, input int x, input int y, input int exp);
    rd_rand = 1'b0;
    rd_x = 6'(x); rd_y = 5'(y);
    tick();
    check(name, int'(rd_cell), exp);
    rd_rand = 1'b1;
  endtask

  task automatic sweep(output int ones);
    rd_rand = 1'b0;
    ones = 0;
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 40; x++) begin
        rd_x = 6'(x); rd_y = 5'(y);
        tick();
        ones += int'(rd_cell);
      end
    end
    rd_rand = 1'b1;
  endtask

  task automatic clear_pat();
    for (int i = 0; i < 1200; i++) pat[i] = 1'b0;
  endtask

  task automatic seed_pattern(input bit with_frame);
    reseed = 1'b1; frame_start = with_frame;
    tick();
    reseed = 1'b0; frame_start = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      seed = pat[k];
      tick();
    end
    seed = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      frame_start = ($urandom_range(0, 7) == 0);
      tick();
      n++;
    end
    frame_start = 1'b0;
    check("idle_timeout", int'(busy === 1'b0), 1);
  endtask

  task automatic run_gen();
    int n;
    for (int p = 0; p < GDIV; p++) begin
      repeat ($urandom_range(0, 3)) tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
    wait_idle(n);
  endtask

  initial begin
    int n, ones;
    rst = 1'b1; seed = 1'b0; reseed = 1'b0; frame_start = 1'b0;
    rd_x = 6'd0; rd_y = 5'd0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_busy", int'(busy), 1);
    check("rst_gen", int'(gen_count), 0);
    check("rst_rd", int'(rd_cell), 0);

    // All-ones seed straight out of reset
    rst = 1'b0; seed = 1'b1;
    repeat (1199) tick();
    check("seed_busy_1199", int'(busy), 1);
    tick();
    check("seed_done_1200", int'(busy), 0);
    seed = 1'b0;
    read_lit("rd_offgrid_x40", 40, 0, 0);
    read_lit("rd_corner", 39, 29, 1);
    read_lit("rd_origin", 0, 0, 1);
    read_lit("rd_offgrid_max", 63, 31, 0);

    // Frame divider: three pulses do nothing, the fourth starts CALC
    for (int i = 0; i < GDIV - 1; i++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
      check("fs_below_div", int'(busy), 0);
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("calc_start", int'(busy), 1);
    wait_idle(n);
    check("gen_len", n, 1201);
    check("gen_one", int'(gen_count), 1);
    read_lit("all_dead_a", 5, 5, 0);
    read_lit("all_dead_b", 39, 29, 0);

    // Horizontal blinker, reseeded with a coincident frame pulse after 3 counted
    for (int i = 0; i < GDIV - 1; i++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
    end
    clear_pat();
    pat[10*40+10] = 1'b1; pat[10*40+11] = 1'b1; pat[10*40+12] = 1'b1;
    seed_pattern(1'b1);
    check("reseed_gen_clr", int'(gen_count), 0);
    run_gen();
    read_lit("blink_11_9", 11, 9, 1);
    read_lit("blink_11_10", 11, 10, 1);
    read_lit("blink_11_11", 11, 11, 1);
    read_lit("blink_10_10", 10, 10, 0);
    read_lit("blink_12_10", 12, 10, 0);
    sweep(ones);
    check("blink_pop", ones, 3);
    run_gen();
    check("blink_gen2", int'(gen_count), 2);
    read_lit("blink2_10_10", 10, 10, 1);
    read_lit("blink2_12_10", 12, 10, 1);
    read_lit("blink2_11_9", 11, 9, 0);

    // Blinker straddling the left/right edge
    clear_pat();
    pat[5*40+39] = 1'b1; pat[5*40+0] = 1'b1; pat[5*40+1] = 1'b1;
    seed_pattern(1'b0);
    run_gen();
    read_lit("wrap_0_4", 0, 4, 1);
    read_lit("wrap_0_5", 0, 5, 1);
    read_lit("wrap_0_6", 0, 6, 1);
    read_lit("wrap_39_5", 39, 5, 0);
    read_lit("wrap_1_5", 1, 5, 0);
    sweep(ones);
    check("wrap_pop", ones, 3);

    // Random soup over several generations
    for (int i = 0; i < 1200; i++) pat[i] = ($urandom_range(0, 9) < 3);
    seed_pattern(1'b0);
    repeat (3) run_gen();
    sweep(ones);

    // Reset in the middle of CALC
    for (int p = 0; p < GDIV; p++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
    end
    repeat (600) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("midcalc_rst_busy", int'(busy), 1);
    check("midcalc_rst_gen", int'(gen_count), 0);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      seed = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    seed = 1'b0;
    check("reseed_len", n, 1200);
    run_gen();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
